// File: rtl/int_priority_controller.sv
// Fixed-priority interrupt controller: edge-detects sources, latches pending, hands one vector at a time to the CPU.
// Latency: source rise at edge k -> pending at edge k -> irq_valid after edge k+1; next request >= 1 cycle after done.
// Backpressure: a request is held (vector stable) until irq_ack; no new request until irq_done closes the ISR.
module int_priority_controller #(
    parameter int NUM_SRC      = 4,
    parameter int VECTOR_WIDTH = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC-1:0]      int_src,
    input  logic [NUM_SRC-1:0]      int_mask,
    input  logic                    global_en,
    output logic                    irq_valid,
    output logic [VECTOR_WIDTH-1:0] irq_vector,
    input  logic                    irq_ack,
    input  logic                    irq_done,
    output logic [NUM_SRC-1:0]      pending,
    output logic                    in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [NUM_SRC-1:0]      r_src_q;
    logic [NUM_SRC-1:0]      r_pending;
    logic [VECTOR_WIDTH-1:0] r_vector;
    logic                    r_valid;
    logic                    r_in_service;

    logic [NUM_SRC-1:0]      w_rise;
    logic [NUM_SRC-1:0]      w_set;
    logic [NUM_SRC-1:0]      w_clr;
    logic [NUM_SRC-1:0]      w_cand;
    logic [VECTOR_WIDTH-1:0] w_winner;
    logic                    w_any;

    assign w_rise = int_src & ~r_src_q;
    assign w_set  = w_rise & int_mask;
    assign w_cand = r_pending & int_mask;

    // Acknowledged vector's pending bit is cleared; only meaningful while a request is outstanding
    always_comb begin
        w_clr = '0;
        if (r_state == ST_REQUEST && irq_ack) begin
            w_clr[r_vector] = 1'b1;
        end
    end

    // Lowest-index enabled pending source wins (scan high to low so the lowest index is written last)
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_winner = VECTOR_WIDTH'(i);
                w_any    = 1'b1;
            end
        end
    end

    // Edge-detect history and pending flags; a new rise beats a same-cycle ack clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src_q   <= '0;
            r_pending <= '0;
        end else begin
            r_src_q   <= int_src;
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Request/service handshake FSM with registered valid, vector and in-service outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_vector     <= '0;
            r_valid      <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (global_en && w_any) begin
                        r_state  <= ST_REQUEST;
                        r_vector <= w_winner;
                        r_valid  <= 1'b1;
                    end
                end
                ST_REQUEST: begin
                    // Mask or enable changes here do not withdraw the request
                    if (irq_ack) begin
                        r_state      <= ST_SERVICE;
                        r_valid      <= 1'b0;
                        r_in_service <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (irq_done) begin
                        r_state      <= ST_IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_valid      <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid  = r_valid;
    assign irq_vector = r_vector;
    assign pending    = r_pending;
    assign in_service = r_in_service;

endmodule

// File: tb/tb_int_priority_controller.sv
// Bench for int_priority_controller: directed vector table followed by randomized traffic against a reference model.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 time unit after the edge.
// The CPU side is modelled by the bench itself; ack/done are driven directly from the table or at random.
module tb_int_priority_controller;

    localparam int NS = 4;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS-1:0] int_src;
    logic [NS-1:0] int_mask;
    logic          global_en;
    logic          irq_valid;
    logic [VW-1:0] irq_vector;
    logic          irq_ack;
    logic          irq_done;
    logic [NS-1:0] pending;
    logic          in_service;

    int n_tests = 0;
    int n_fail  = 0;

    int_priority_controller #(.NUM_SRC(NS), .VECTOR_WIDTH(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .int_src    (int_src),
        .int_mask   (int_mask),
        .global_en  (global_en),
        .irq_valid  (irq_valid),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NS-1:0] src;
        logic [NS-1:0] mask;
        logic          gen;
        logic          ack;
        logic          done;
        logic          e_valid;
        logic [VW-1:0] e_vec;
        logic [NS-1:0] e_pend;
        logic          e_insvc;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rst, input logic [3:0] src, input logic [3:0] mask, input logic gen,
                       input logic ack, input logic done, input logic ev, input logic [1:0] evec,
                       input logic [3:0] epend, input logic eis);
        vec_t v;
        v.rst = rst; v.src = src; v.mask = mask; v.gen = gen; v.ack = ack; v.done = done;
        v.e_valid = ev; v.e_vec = evec; v.e_pend = epend; v.e_insvc = eis;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Reference model: pending as a bit array, controller phase as a small integer
    int       m_phase;   // 0 idle, 1 requesting, 2 servicing
    int       m_vec;
    bit       m_pend[NS];
    bit       m_prev[NS];

    task automatic model_step(input logic rst, input logic [NS-1:0] src, input logic [NS-1:0] mask,
                              input logic gen, input logic ack, input logic done);
        bit old[NS];
        int win;
        if (!rst) begin
            m_phase = 0;
            m_vec   = 0;
            for (int i = 0; i < NS; i++) begin
                m_pend[i] = 0;
                m_prev[i] = 0;
            end
        end else begin
            for (int i = 0; i < NS; i++) old[i] = m_pend[i];
            if (m_phase == 1 && ack) m_pend[m_vec] = 0;
            for (int i = 0; i < NS; i++)
                if (src[i] && !m_prev[i] && mask[i]) m_pend[i] = 1;
            win = -1;
            for (int i = NS - 1; i >= 0; i--)
                if (old[i] && mask[i]) win = i;
            case (m_phase)
                0: if (gen && win >= 0) begin m_phase = 1; m_vec = win; end
                1: if (ack) m_phase = 2;
                default: if (done) m_phase = 0;
            endcase
            for (int i = 0; i < NS; i++) m_prev[i] = src[i];
        end
    endtask

    function automatic logic [NS-1:0] model_pend();
        logic [NS-1:0] p;
        for (int i = 0; i < NS; i++) p[i] = m_pend[i];
        return p;
    endfunction

    initial begin
        rst_n = 1'b0; int_src = '0; int_mask = 4'hF; global_en = 1'b1; irq_ack = 1'b0; irq_done = 1'b0;

        //   rst src    mask   gen ack done | valid vec pend   insvc
        // Reset held with all sources high, then released with sources low
        row(0, 4'hF, 4'hF, 1, 0, 0,  0, 0, 4'h0, 0);
        row(0, 4'hF, 4'hF, 1, 0, 0,  0, 0, 4'h0, 0);
        row(0, 4'h0, 4'hF, 1, 0, 0,  0, 0, 4'h0, 0);
        row(1, 4'h0, 4'hF, 1, 0, 0,  0, 0, 4'h0, 0);
        // Single held source 2: one event only
        row(1, 4'h4, 4'hF, 1, 0, 0,  0, 0, 4'h4, 0);
        row(1, 4'h4, 4'hF, 1, 0, 0,  1, 2, 4'h4, 0);
        row(1, 4'h4, 4'hF, 1, 1, 0,  0, 2, 4'h0, 1);
        row(1, 4'h4, 4'hF, 1, 0, 0,  0, 2, 4'h0, 1);
        row(1, 4'h4, 4'hF, 1, 0, 1,  0, 2, 4'h0, 0);
        row(1, 4'h4, 4'hF, 1, 0, 0,  0, 2, 4'h0, 0);
        row(1, 4'h0, 4'hF, 1, 0, 0,  0, 2, 4'h0, 0);
        // Priority: sources 3 and 1 together
        row(1, 4'hA, 4'hF, 1, 0, 0,  0, 2, 4'hA, 0);
        row(1, 4'hA, 4'hF, 1, 0, 0,  1, 1, 4'hA, 0);
        row(1, 4'h0, 4'hF, 1, 1, 0,  0, 1, 4'h8, 1);
        row(1, 4'h0, 4'hF, 1, 0, 1,  0, 1, 4'h8, 0);
        row(1, 4'h0, 4'hF, 1, 0, 0,  1, 3, 4'h8, 0);
        row(1, 4'h0, 4'hF, 1, 1, 0,  0, 3, 4'h0, 1);
        row(1, 4'h0, 4'hF, 1, 0, 1,  0, 3, 4'h0, 0);
        // Collision: rise of source 2 on the ack edge for vector 2
        row(1, 4'h4, 4'hF, 1, 0, 0,  0, 3, 4'h4, 0);
        row(1, 4'h0, 4'hF, 1, 0, 0,  1, 2, 4'h4, 0);
        row(1, 4'h4, 4'hF, 1, 1, 0,  0, 2, 4'h4, 1);
        row(1, 4'h4, 4'hF, 1, 0, 1,  0, 2, 4'h4, 0);
        row(1, 4'h4, 4'hF, 1, 0, 0,  1, 2, 4'h4, 0);
        row(1, 4'h0, 4'hF, 1, 1, 0,  0, 2, 4'h0, 1);
        row(1, 4'h0, 4'hF, 1, 0, 1,  0, 2, 4'h0, 0);
        // Reset mid-service with pending 1010, then stray ack/done
        row(1, 4'hA, 4'hF, 1, 0, 0,  0, 2, 4'hA, 0);
        row(1, 4'h0, 4'hF, 1, 0, 0,  1, 1, 4'hA, 0);
        row(1, 4'h2, 4'hF, 1, 1, 0,  0, 1, 4'hA, 1);
        row(0, 4'h0, 4'hF, 1, 0, 0,  0, 0, 4'h0, 0);
        row(1, 4'h0, 4'hF, 1, 1, 1,  0, 0, 4'h0, 0);
        row(1, 4'h0, 4'hF, 1, 0, 1,  0, 0, 4'h0, 0);
        // Mask: masked rise discarded; masked pending bit held but not arbitrated
        row(1, 4'h1, 4'hE, 1, 0, 0,  0, 0, 4'h0, 0);
        row(1, 4'h0, 4'hE, 1, 0, 0,  0, 0, 4'h0, 0);
        row(1, 4'h2, 4'hF, 1, 0, 0,  0, 0, 4'h2, 0);
        row(1, 4'h0, 4'hD, 1, 0, 0,  0, 0, 4'h2, 0);
        row(1, 4'h0, 4'hD, 1, 0, 0,  0, 0, 4'h2, 0);
        row(1, 4'h0, 4'hF, 1, 0, 0,  1, 1, 4'h2, 0);
        row(1, 4'h0, 4'h0, 0, 0, 0,  1, 1, 4'h2, 0);
        row(1, 4'h0, 4'hF, 1, 1, 0,  0, 1, 4'h0, 1);
        row(1, 4'h0, 4'hF, 1, 0, 1,  0, 1, 4'h0, 0);

        foreach (vecs[k]) begin
            rst_n = vecs[k].rst; int_src = vecs[k].src; int_mask = vecs[k].mask;
            global_en = vecs[k].gen; irq_ack = vecs[k].ack; irq_done = vecs[k].done;
            @(posedge clk); #1;
            chk("dir_valid",  k, 32'(irq_valid),  32'(vecs[k].e_valid));
            chk("dir_pend",   k, 32'(pending),    32'(vecs[k].e_pend));
            chk("dir_insvc",  k, 32'(in_service), 32'(vecs[k].e_insvc));
            chk("dir_vector", k, 32'(irq_vector), 32'(vecs[k].e_vec));
        end

        // Randomized traffic; first cycle is a reset so the model starts aligned
        for (int c = 0; c < 2000; c++) begin
            rst_n     = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            int_src   = NS'($urandom & $urandom);
            int_mask  = ($urandom_range(0, 3) == 0) ? NS'($urandom) : 4'hF;
            global_en = ($urandom_range(0, 7) != 0);
            irq_ack   = ($urandom_range(0, 2) == 0);
            irq_done  = ($urandom_range(0, 3) == 0);
            model_step(rst_n, int_src, int_mask, global_en, irq_ack, irq_done);
            @(posedge clk); #1;
            chk("rnd_valid",  c, 32'(irq_valid),  32'(m_phase == 1));
            chk("rnd_insvc",  c, 32'(in_service), 32'(m_phase == 2));
            chk("rnd_pend",   c, 32'(pending),    32'(model_pend()));
            chk("rnd_vector", c, 32'(irq_vector), 32'(m_vec));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
